// File: rtl/sample_stream_buffer.sv
// rtl/sample_stream_buffer.sv - decimating sample capture into a show-ahead FIFO with drop accounting
//
// Purpose: takes one sample from a free-running source every (decim_i+1)
// cycles while enabled, buffers it in a show-ahead FIFO and hands it to the
// consumer over a valid/ready handshake. Captures that find the FIFO full
// (with no pop the same cycle) are dropped, and each drop is recorded.
//
// Ports:
//   clk, rst_ni           clock (rising edge), asynchronous active-low reset
//   en_i                  capture enable
//   clear_i               synchronous flush of FIFO, overflow flag and drop count
//   decim_i               capture period minus one (0 = every cycle)
//   sample_i              source sample, new value every cycle
//   sample_o, valid_o     FIFO head and its valid flag
//   ready_i               consumer accepts sample_o
//   level_o               FIFO occupancy (0..DEPTH)
//   overflow_o            sticky: at least one sample dropped
//   drop_cnt_o            dropped-sample count, saturating at all-ones
module sample_stream_buffer #(
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 16,
    parameter int DECIM_W = 16,
    parameter int DROP_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [DECIM_W-1:0]       decim_i,
    input  logic [DATA_W-1:0]        sample_i,
    output logic [DATA_W-1:0]        sample_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DECIM_W-1:0]   r_cnt;
    logic [DECIM_W-1:0]   w_cnt_nxt;
    logic                 w_capture;

    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_overflow;
    logic [DROP_W-1:0]    r_drop_cnt;

    logic                 w_valid;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_write;
    logic                 w_drop;

    // Capture phase FSM; clear_i deliberately leaves state and phase alone.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en_i) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (!en_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_capture = (r_cnt == '0);
                    // >= rather than == so a shrinking decim_i still wraps the phase.
                    w_cnt_nxt = (r_cnt >= decim_i) ? '0 : r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == FULL_LEVEL);
    assign w_pop   = w_valid && ready_i;
    // A full FIFO still takes the capture when the head leaves in the same cycle.
    assign w_write = w_capture && (!w_full || w_pop);
    assign w_drop  = w_capture && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_write && !clear_i) begin
            r_mem[r_wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    // Head is gated to zero while empty so the output is defined without resetting memory.
    assign sample_o   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign valid_o    = w_valid;
    assign level_o    = r_level;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_sample_stream_buffer.sv
// tb/tb_sample_stream_buffer.sv - self-checking bench for sample_stream_buffer
module tb_sample_stream_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] dec = '0;
    logic [23:0] smp = '0;
    logic [23:0] s_out;
    logic        v_out;
    logic [4:0]  lvl;
    logic        ovf;
    logic [7:0]  drp;

    int nerr = 0;
    int ncheck = 0;

    // Reference model: a queue of buffered samples plus run/phase bookkeeping.
    logic [23:0] m_q[$];
    bit          m_on;
    int          m_cnt;
    bit          m_ovf;
    int          m_drop;

    typedef struct {
        logic        en;
        logic        clr;
        logic        rdy;
        logic [15:0] dec;
        logic        exp_valid;
        int          exp_level;
        logic [23:0] exp_sample;
    } vec_t;

    vec_t tbl[16];

    sample_stream_buffer dut (
        .clk        (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .clear_i    (clr),
        .decim_i    (dec),
        .sample_i   (smp),
        .sample_o   (s_out),
        .valid_o    (v_out),
        .ready_i    (rdy),
        .level_o    (lvl),
        .overflow_o (ovf),
        .drop_cnt_o (drp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_on   = 1'b0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_update();
        bit pop;
        bit cap;
        pop = (m_q.size() > 0) && rdy;
        cap = m_on && en && (m_cnt == 0);
        if (m_on) begin
            if (!en) m_on = 1'b0;
            else     m_cnt = (m_cnt >= int'(dec)) ? 0 : m_cnt + 1;
        end else if (en) begin
            m_on  = 1'b1;
            m_cnt = 0;
        end
        if (clr) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (cap) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(smp);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("m_valid", 32'(v_out), 32'(m_q.size() > 0));
        chk("m_level", 32'(lvl), 32'(m_q.size()));
        chk("m_overflow", 32'(ovf), 32'(m_ovf));
        chk("m_drop", 32'(drp), 32'(m_drop));
        if (m_q.size() > 0) chk("m_sample", 32'(s_out), 32'(m_q[0]));
    endtask

    // One clock: inputs already set; model advances, edge, sample 1 time unit later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        model_check();
        smp = smp + 1'b1;
    endtask

    task automatic set_in(input logic e, input logic c, input logic r, input logic [15:0] d);
        en = e; clr = c; rdy = r; dec = d;
    endtask

    initial begin
        logic [23:0] first;

        //                en    clr   rdy   dec    valid lvl smp
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 0, 24'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1, 24'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 2, 24'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'd0, 1'b1, 2, 24'd2};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1, 24'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1, 24'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 0, 24'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 0, 24'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1, 24'd8};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1, 24'd8};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1, 24'd8};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 2, 24'd8};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 0, 24'd0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 0, 24'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1, 24'd14};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 0, 24'd0};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(v_out), 32'd0);
        chk("rst_level", 32'(lvl), 32'd0);
        chk("rst_overflow", 32'(ovf), 32'd0);
        chk("rst_drop", 32'(drp), 32'd0);
        chk("rst_sample", 32'(s_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        smp = '0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].en, tbl[i].clr, tbl[i].rdy, tbl[i].dec);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(v_out), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_level", i), 32'(lvl), 32'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_overflow", i), 32'(ovf), 32'd0);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_sample", i), 32'(s_out), 32'(tbl[i].exp_sample));
        end

        // Streaming ramp with decim 0, then decim 3 shrinking to 1
        set_in(1'b1, 1'b1, 1'b1, 16'd0);
        step();
        set_in(1'b1, 1'b0, 1'b1, 16'd0);
        repeat (20) step();
        chk("stream_level", 32'(lvl), 32'd1);
        chk("stream_valid", 32'(v_out), 32'd1);
        dec = 16'd3;
        repeat (9) step();
        dec = 16'd1;
        repeat (6) step();

        // Overflow: 20 captures into a 16-deep FIFO with no consumer
        set_in(1'b1, 1'b1, 1'b0, 16'd0);
        step();
        clr = 1'b0;
        first = smp;
        repeat (20) step();
        chk("ovf_level", 32'(lvl), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_drop", 32'(drp), 32'd4);
        chk("ovf_head", 32'(s_out), 32'(first));
        set_in(1'b0, 1'b0, 1'b1, 16'd0);
        repeat (16) step();
        chk("drain_valid", 32'(v_out), 32'd0);

        // Full FIFO with simultaneous pop and capture, then drop saturation
        set_in(1'b1, 1'b0, 1'b0, 16'd0);
        repeat (17) step();
        rdy = 1'b1;
        step();
        chk("fullpop_level", 32'(lvl), 32'd16);
        chk("fullpop_drop", 32'(drp), 32'd4);
        rdy = 1'b0;
        repeat (300) step();
        chk("sat_drop", 32'(drp), 32'd255);

        // Drain to level 5, then clear
        set_in(1'b0, 1'b0, 1'b1, 16'd0);
        repeat (11) step();
        chk("pre_clr_level", 32'(lvl), 32'd5);
        chk("pre_clr_ovf", 32'(ovf), 32'd1);
        set_in(1'b0, 1'b1, 1'b0, 16'd0);
        step();
        chk("clr_level", 32'(lvl), 32'd0);
        chk("clr_valid", 32'(v_out), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_drop", 32'(drp), 32'd0);

        // Enable dropped with three entries buffered
        set_in(1'b1, 1'b0, 1'b0, 16'd0);
        repeat (4) step();
        chk("en_off_level", 32'(lvl), 32'd3);
        set_in(1'b0, 1'b0, 1'b1, 16'd0);
        repeat (4) step();
        chk("en_off_valid", 32'(v_out), 32'd0);
        chk("en_off_level0", 32'(lvl), 32'd0);

        // Asynchronous reset mid-stream
        set_in(1'b1, 1'b0, 1'b0, 16'd0);
        repeat (3) step();
        set_in(1'b1, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b0;
        #2;
        chk("arst_valid", 32'(v_out), 32'd0);
        chk("arst_level", 32'(lvl), 32'd0);
        chk("arst_sample", 32'(s_out), 32'd0);
        chk("arst_drop", 32'(drp), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 127) == 0);
            rdy = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0) dec = 16'($urandom_range(0, 4));
            smp = 24'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

endmodule

// File: doc/sample_stream_buffer.md
# sample_stream_buffer

Capture stage between the free-running 24-bit sine sample source and the FIR filter input. Takes one sample from the source every (decim_i+1) clock cycles while enabled, stores samples in a show-ahead FIFO and presents them to the filter over a valid/ready handshake. Dropped samples on a full FIFO are reported through a sticky flag and a saturating counter.

## Interface
- DATA_W, 24, sample width
- DEPTH, 16, FIFO entries; power of two, ≥2
- DECIM_W, 16, width of decimation control
- DROP_W, 8, width of drop counter
- clk  input  1  clock; all logic on rising edge
- rst_ni  input  1  reset; asynchronous, active-low
- en_i  input  1  capture enable
- clear_i  input  1  synchronous flush: empties FIFO, clears overflow_o and drop_cnt_o
- decim_i  input  DECIM_W  capture period minus one (0 = every cycle)
- sample_i  input  DATA_W  sample from source, new value every cycle
- sample_o  output  DATA_W  FIFO head sample
- valid_o  output  1  sample_o valid
- ready_i  input  1  consumer accepts sample_o
- level_o  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow_o  output  1  sticky: at least one sample dropped
- drop_cnt_o  output  DROP_W  dropped-sample count, saturates at all-ones

## Operation
- FSM states IDLE, RUN. Reset state IDLE.
- IDLE: no captures. en_i=1 → RUN, phase counter cnt←0.
- RUN: en_i=0 → IDLE (no capture in that cycle). Otherwise capture when cnt==0; cnt←(cnt≥decim_i) ? 0 : cnt+1. Using ≥ guarantees wrap when decim_i shrinks mid-run; new decim_i takes effect immediately through the comparison.
- Capture writes sample_i into FIFO at wr_ptr.
- Pop occurs when valid_o && ready_i; rd_ptr advances.
- Full (level_o==DEPTH): capture is accepted only if a pop happens the same cycle (level unchanged); otherwise sample dropped, overflow_o←1, drop_cnt_o←drop_cnt_o+1 unless all-ones.
- Empty: valid_o=0; ready_i ignored; sample_o don't-care.
- Pointers are $clog2(DEPTH)-bit and wrap naturally; level_o is a separate counter (+1 on write-only, −1 on pop-only, unchanged on both/neither).
- clear_i=1: pointers, level, overflow_o, drop_cnt_o ← 0; any capture or pop that cycle is discarded; FSM state and cnt unaffected. clear_i has priority over all other actions.
- FIFO drains in both IDLE and RUN.

## Timing
- Reset values: valid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0, sample_o=0 (memory contents need no reset; sample_o gated to 0 while empty is not required after reset).
- en_i rises at edge N → state RUN after N; first capture at edge N+1 of sample_i present in that cycle.
- Capture at edge K into empty FIFO → valid_o=1, sample_o=captured value after edge K (show-ahead, 1-cycle latency).
- sample_o and valid_o hold stable while valid_o=1 and ready_i=0.
- With decim_i=D held, captures spaced exactly D+1 cycles.
- Continuous ready_i=1 with decim_i=0: one capture and one pop per cycle, level_o stays 1 after first capture.
- Reset assertion mid-operation: all state cleared immediately, outputs at reset values; no partial pop/write.

## Test plan
- Reset, en_i=1, decim_i=0, ready_i=1, sample_i ramp 0,1,2,…: sample_o sequence equals ramp with 1-cycle lag, valid_o continuously 1 after first capture, overflow_o=0.
- decim_i=3, ramp input, ready_i=1: accepted samples 0,4,8,12,… (relative to first capture); change decim_i to 1 with cnt=3 → next capture next cycle, then every 2 cycles.
- ready_i=0, decim_i=0, DEPTH=16, run 20 capture cycles: level_o=16, overflow_o=1, drop_cnt_o=4; then ready_i=1 yields the first 16 samples in order.
- Full FIFO with ready_i=1 and capture same cycle: level_o stays 16, no drop counted; run 300 drops with ready_i=0: drop_cnt_o saturates at 255.
- clear_i pulse with level_o=5, overflow_o=1: next cycle level_o=0, valid_o=0, overflow_o=0, drop_cnt_o=0; captures resume per cnt.
- en_i dropped mid-run with level_o=3, ready_i=1: no new captures, three pops, valid_o falls; rst_ni asserted mid-stream clears all outputs asynchronously.
